// File: rtl/rs_dispatch_credit_if.sv
// Dispatch-side bundle between decode/rename and the RS credit tracker.
// The master side is decode/rename (drives the group and the releases).
// The slave side is the credit tracker (returns requests, credits and accept).
interface rs_dispatch_credit_if #(
    parameter int DISP_WIDTH = 2,
    parameter int NUM_TYPES  = 6,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 4,
    parameter int NUM_W      = 2,
    parameter int REL_W      = 2
) ();

    logic [DISP_WIDTH*SEL_W-1:0]     rsent;
    logic [DISP_WIDTH-1:0]           disp_valid;
    logic                            stall_in;
    logic                            flush;
    logic [NUM_TYPES*REL_W-1:0]      release_num;

    logic [NUM_TYPES*DISP_WIDTH-1:0] req_vec;
    logic [NUM_TYPES*NUM_W-1:0]      req_num;
    logic                            disp_accept;
    logic                            disp_stall;
    logic [NUM_TYPES*CNT_W-1:0]      free_cnt;
    logic [NUM_TYPES-1:0]            rs_full;
    logic                            ovf_err;

    modport master (
        output rsent, disp_valid, stall_in, flush, release_num,
        input  req_vec, req_num, disp_accept, disp_stall, free_cnt, rs_full, ovf_err
    );

    modport slave (
        input  rsent, disp_valid, stall_in, flush, release_num,
        output req_vec, req_num, disp_accept, disp_stall, free_cnt, rs_full, ovf_err
    );

endinterface

// File: rtl/rs_dispatch_credit.sv
// N-wide dispatch RS request generator with per-type free-entry credits.
// Each slot's RS-type select is decoded into per-type request vectors and
// counts. A group is accepted only when every type has enough registered
// credits (all-or-nothing). Credits are consumed on accept and returned by
// the RS banks via release_num; changes become visible one cycle later.
module rs_dispatch_credit #(
    parameter int DISP_WIDTH = 2,
    parameter int NUM_TYPES  = 6,
    parameter int SEL_W      = 3,
    parameter int ENT_NUM    = 8,
    parameter int CNT_W      = 4,
    parameter int NUM_W      = 2,
    parameter int REL_W      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    rs_dispatch_credit_if.slave  bus
);

    // Arithmetic width wide enough that credit + release never wraps.
    localparam int MAX_W  = (CNT_W > REL_W) ? ((CNT_W > NUM_W) ? CNT_W : NUM_W)
                                            : ((REL_W > NUM_W) ? REL_W : NUM_W);
    localparam int CALC_W = MAX_W + 1;

    localparam logic [CNT_W-1:0]  ENT_CNT  = CNT_W'(ENT_NUM);
    localparam logic [CALC_W-1:0] ENT_CALC = CALC_W'(ENT_NUM);

    logic [SEL_W-1:0]            slot_sel   [DISP_WIDTH];
    logic [REL_W-1:0]            rel_cnt    [NUM_TYPES];
    logic [NUM_W-1:0]            req_cnt    [NUM_TYPES];
    logic [CNT_W-1:0]            credit     [NUM_TYPES];
    logic [CNT_W-1:0]            credit_nxt [NUM_TYPES];
    logic [CALC_W-1:0]           credit_sum [NUM_TYPES];
    logic [NUM_TYPES-1:0]        ovf_hit;

    logic [NUM_TYPES*DISP_WIDTH-1:0] req_vec_c;
    logic [NUM_TYPES*NUM_W-1:0]      req_num_c;
    logic [NUM_TYPES*CNT_W-1:0]      free_cnt_c;
    logic [NUM_TYPES-1:0]            rs_full_c;

    logic need_ok;
    logic any_valid;
    logic accept;
    logic ovf_err_q;

    // Split the packed select and release buses into per-slot / per-type fields.
    always_comb begin
        for (int i = 0; i < DISP_WIDTH; i++) begin
            slot_sel[i] = bus.rsent[i*SEL_W +: SEL_W];
        end
        for (int t = 0; t < NUM_TYPES; t++) begin
            rel_cnt[t] = bus.release_num[t*REL_W +: REL_W];
        end
    end

    // Decode each valid slot into a one-hot request; selects 0 or above NUM_TYPES request nothing.
    always_comb begin
        req_vec_c = '0;
        for (int t = 0; t < NUM_TYPES; t++) begin
            for (int i = 0; i < DISP_WIDTH; i++) begin
                if (bus.disp_valid[i] && (int'(slot_sel[i]) == t + 1)) begin
                    req_vec_c[t*DISP_WIDTH + i] = 1'b1;
                end
            end
        end
    end

    // Per-type popcount of the request vector.
    always_comb begin
        req_num_c = '0;
        for (int t = 0; t < NUM_TYPES; t++) begin
            req_cnt[t] = '0;
            for (int i = 0; i < DISP_WIDTH; i++) begin
                req_cnt[t] = req_cnt[t] + NUM_W'(req_vec_c[t*DISP_WIDTH + i]);
            end
            req_num_c[t*NUM_W +: NUM_W] = req_cnt[t];
        end
    end

    // Credit check against registered credits only; releases this cycle do not help.
    always_comb begin
        need_ok = 1'b1;
        for (int t = 0; t < NUM_TYPES; t++) begin
            if (CALC_W'(req_cnt[t]) > CALC_W'(credit[t])) begin
                need_ok = 1'b0;
            end
        end
    end

    // Group-level accept/stall; nothing is accepted while reset is held.
    always_comb begin
        any_valid = |bus.disp_valid;
        accept    = any_valid & ~bus.stall_in & ~bus.flush & need_ok & ~reset;
    end

    // Next credit per type: consume on accept, add releases, clamp above ENT_NUM.
    always_comb begin
        ovf_hit = '0;
        for (int t = 0; t < NUM_TYPES; t++) begin
            credit_sum[t] = CALC_W'(credit[t]) + CALC_W'(rel_cnt[t]);
            if (accept) begin
                credit_sum[t] = credit_sum[t] - CALC_W'(req_cnt[t]);
            end
            if (credit_sum[t] > ENT_CALC) begin
                credit_nxt[t] = ENT_CNT;
                ovf_hit[t]    = ~bus.flush;
            end else begin
                credit_nxt[t] = CNT_W'(credit_sum[t]);
            end
        end
    end

    // Credit registers: reset and flush both refill every RS to ENT_NUM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_TYPES; t++) begin
                credit[t] <= ENT_CNT;
            end
        end else if (bus.flush) begin
            for (int t = 0; t < NUM_TYPES; t++) begin
                credit[t] <= ENT_CNT;
            end
        end else begin
            for (int t = 0; t < NUM_TYPES; t++) begin
                credit[t] <= credit_nxt[t];
            end
        end
    end

    // Sticky over-release flag; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_err_q <= 1'b0;
        end else if (|ovf_hit) begin
            ovf_err_q <= 1'b1;
        end
    end

    // Pack registered credits and derive full flags straight from them.
    always_comb begin
        free_cnt_c = '0;
        rs_full_c  = '0;
        for (int t = 0; t < NUM_TYPES; t++) begin
            free_cnt_c[t*CNT_W +: CNT_W] = credit[t];
            rs_full_c[t]                 = (credit[t] == '0);
        end
    end

    assign bus.req_vec     = req_vec_c;
    assign bus.req_num     = req_num_c;
    assign bus.disp_accept = accept;
    assign bus.disp_stall  = any_valid & ~accept;
    assign bus.free_cnt    = free_cnt_c;
    assign bus.rs_full     = rs_full_c;
    assign bus.ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_rs_dispatch_credit.sv
// Directed bench for rs_dispatch_credit with the default 2-wide, 6-type,
// 8-entry configuration. Expected values are hand-computed constants.
module tb_rs_dispatch_credit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    rs_dispatch_credit_if #(
        .DISP_WIDTH(2), .NUM_TYPES(6), .SEL_W(3),
        .CNT_W(4), .NUM_W(2), .REL_W(2)
    ) bus ();

    rs_dispatch_credit #(
        .DISP_WIDTH(2), .NUM_TYPES(6), .SEL_W(3), .ENT_NUM(8),
        .CNT_W(4), .NUM_W(2), .REL_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    // Drive one input vector and let the combinational outputs settle.
    task automatic applyStimulus(input logic [5:0] rsent, input logic [1:0] valid,
                                 input logic stall, input logic fl,
                                 input logic [11:0] rel);
        bus.rsent       = rsent;
        bus.disp_valid  = valid;
        bus.stall_in    = stall;
        bus.flush       = fl;
        bus.release_num = rel;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int fc(input int t);
        return int'(bus.free_cnt[t*4 +: 4]);
    endfunction

    function automatic int rn(input int t);
        return int'(bus.req_num[t*2 +: 2]);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(6'o11, 2'b11, 1'b0, 1'b0, 12'h000);
        checkOutput("accept_in_reset", int'(bus.disp_accept), 0);
        tick();
        tick();
        checkOutput("reset_free_all", int'(bus.free_cnt), 'h888888);
        checkOutput("reset_rs_full", int'(bus.rs_full), 0);
        checkOutput("reset_ovf", int'(bus.ovf_err), 0);

        // First ALU pair.
        reset = 1'b0;
        applyStimulus(6'o11, 2'b11, 1'b0, 1'b0, 12'h000);
        checkOutput("alu_pair_req_vec", int'(bus.req_vec), 'h003);
        checkOutput("alu_pair_req_num0", rn(0), 2);
        checkOutput("alu_pair_req_num_all", int'(bus.req_num), 'h002);
        checkOutput("alu_pair_accept", int'(bus.disp_accept), 1);
        checkOutput("alu_pair_stall", int'(bus.disp_stall), 0);
        tick();
        checkOutput("free0_after_1", fc(0), 6);

        // Three more pairs drain type 0.
        tick();
        checkOutput("free0_after_2", fc(0), 4);
        tick();
        checkOutput("free0_after_3", fc(0), 2);
        tick();
        checkOutput("free0_after_4", fc(0), 0);
        checkOutput("rs_full_type0", int'(bus.rs_full), 'b000001);
        checkOutput("fifth_accept", int'(bus.disp_accept), 0);
        checkOutput("fifth_stall", int'(bus.disp_stall), 1);
        tick();
        checkOutput("free0_stalled", fc(0), 0);

        // Return one credit with no group present.
        applyStimulus(6'o00, 2'b00, 1'b0, 1'b0, 12'h001);
        checkOutput("idle_accept", int'(bus.disp_accept), 0);
        checkOutput("idle_stall", int'(bus.disp_stall), 0);
        tick();
        checkOutput("free0_released", fc(0), 1);

        // Two ALUs with one credit stall; ALU+MUL passes.
        applyStimulus(6'o11, 2'b11, 1'b0, 1'b0, 12'h000);
        checkOutput("alu_pair_one_credit_stall", int'(bus.disp_stall), 1);
        checkOutput("alu_pair_one_credit_accept", int'(bus.disp_accept), 0);
        applyStimulus(6'o31, 2'b11, 1'b0, 1'b0, 12'h000);
        checkOutput("alu_mul_req_vec", int'(bus.req_vec), 'h021);
        checkOutput("alu_mul_accept", int'(bus.disp_accept), 1);
        tick();
        checkOutput("alu_mul_free0", fc(0), 0);
        checkOutput("alu_mul_free2", fc(2), 7);

        // Bring type 3 down to 5.
        applyStimulus(6'o44, 2'b11, 1'b0, 1'b0, 12'h000);
        tick();
        applyStimulus(6'o04, 2'b01, 1'b0, 1'b0, 12'h000);
        tick();
        checkOutput("ldst_free3_setup", fc(3), 5);

        // Dispatch two and release two on type 3 in the same cycle.
        applyStimulus(6'o44, 2'b11, 1'b0, 1'b0, 12'h080);
        checkOutput("ldst_net_accept", int'(bus.disp_accept), 1);
        tick();
        checkOutput("ldst_net_free3", fc(3), 5);

        // NOP-class slot dispatches without touching credits.
        applyStimulus(6'o00, 2'b01, 1'b0, 1'b0, 12'h000);
        checkOutput("nop_req_vec", int'(bus.req_vec), 0);
        checkOutput("nop_accept", int'(bus.disp_accept), 1);
        tick();
        checkOutput("nop_free_vec", int'(bus.free_cnt), 'h885780);

        // Select above NUM_TYPES also requests nothing.
        applyStimulus(6'o07, 2'b01, 1'b0, 1'b0, 12'h000);
        checkOutput("sel7_req_vec", int'(bus.req_vec), 0);
        checkOutput("sel7_accept", int'(bus.disp_accept), 1);
        tick();

        // Over-release on type 1.
        applyStimulus(6'o02, 2'b01, 1'b0, 1'b0, 12'h000);
        tick();
        checkOutput("free1_seven", fc(1), 7);
        checkOutput("ovf_before", int'(bus.ovf_err), 0);
        applyStimulus(6'o00, 2'b00, 1'b0, 1'b0, 12'h008);
        tick();
        checkOutput("free1_clamped", fc(1), 8);
        checkOutput("ovf_set", int'(bus.ovf_err), 1);

        // Flush with a valid group and releases pending.
        applyStimulus(6'o33, 2'b11, 1'b0, 1'b1, 12'h555);
        checkOutput("flush_accept", int'(bus.disp_accept), 0);
        checkOutput("flush_stall", int'(bus.disp_stall), 1);
        tick();
        checkOutput("flush_free_vec", int'(bus.free_cnt), 'h888888);
        checkOutput("flush_rs_full", int'(bus.rs_full), 0);
        checkOutput("flush_ovf_sticky", int'(bus.ovf_err), 1);

        // External stall holds credits.
        applyStimulus(6'o11, 2'b11, 1'b1, 1'b0, 12'h000);
        checkOutput("stall_in_accept", int'(bus.disp_accept), 0);
        checkOutput("stall_in_stall", int'(bus.disp_stall), 1);
        tick();
        checkOutput("stall_in_free0", fc(0), 8);

        // Reset clears the sticky flag.
        applyStimulus(6'o00, 2'b00, 1'b0, 1'b0, 12'h000);
        reset = 1'b1;
        tick();
        checkOutput("reset_ovf_clear", int'(bus.ovf_err), 0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
